// File: rtl/hdb3_bnzs_encoder_pkg.sv
// rtl/hdb3_bnzs_encoder_pkg.sv - shared symbol codes and delay-line entry kinds
// Purpose: symbol codes driven onto the ternary line and the kinds of entry
// held in the encoder delay line.
package hdb3_pkg;

  localparam logic [1:0] SYM_ZERO = 2'b00;
  localparam logic [1:0] SYM_POS  = 2'b01;
  localparam logic [1:0] SYM_NEG  = 2'b11;

  typedef enum logic [1:0] {
    K_ZERO = 2'd0,
    K_ONE  = 2'd1,
    K_B    = 2'd2,
    K_V    = 2'd3
  } kind_t;

endpackage

// File: rtl/hdb3_bnzs_encoder_if.sv
// rtl/hdb3_bnzs_encoder_if.sv - NRZ input / ternary output bundle of the encoder
// Purpose: groups the input handshake and the symbol output.
// Ports:
//   in_valid, in_data        : NRZ bit and its accept strobe (no backpressure)
//   out_valid                : symbol fields valid this cycle
//   out_sym, out_v, out_b    : line symbol (00/01/11), V and B markers
// Modports: master drives the input side, slave is the encoder itself.
interface hdb3_bnzs_encoder_if;

  logic       in_valid;
  logic       in_data;
  logic       out_valid;
  logic [1:0] out_sym;
  logic       out_v;
  logic       out_b;

  modport master (
    output in_valid, in_data,
    input  out_valid, out_sym, out_v, out_b
  );

  modport slave (
    input  in_valid, in_data,
    output out_valid, out_sym, out_v, out_b
  );

endinterface

// File: rtl/hdb3_bnzs_encoder_polarity.sv
// rtl/hdb3_bnzs_encoder_polarity.sv - AMI polarity assignment of delay-line entries
// Purpose: turns an entry kind into a signed line symbol, tracking the
// polarity of the last nonzero symbol emitted.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   en              : register a new symbol from kind this cycle
//   kind            : entry leaving the delay line
//   out_sym         : registered line symbol
//   out_v, out_b    : registered V / B markers
module hdb3_polarity
  import hdb3_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  kind_t      kind,
  output logic [1:0] out_sym,
  output logic       out_v,
  output logic       out_b
);

  // last_neg=1 means the last nonzero symbol was -1; reset so the first pulse is +1.
  logic last_neg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_neg <= 1'b1;
      out_sym  <= SYM_ZERO;
      out_v    <= 1'b0;
      out_b    <= 1'b0;
    end else if (en) begin
      case (kind)
        K_ONE, K_B: begin
          out_sym  <= last_neg ? SYM_POS : SYM_NEG;
          last_neg <= ~last_neg;
          out_v    <= 1'b0;
          out_b    <= (kind == K_B);
        end
        K_V: begin
          // Violation repeats the previous polarity and leaves it unchanged.
          out_sym <= last_neg ? SYM_NEG : SYM_POS;
          out_v   <= 1'b1;
          out_b   <= 1'b0;
        end
        default: begin
          out_sym <= SYM_ZERO;
          out_v   <= 1'b0;
          out_b   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/hdb3_bnzs_encoder.sv
// rtl/hdb3_bnzs_encoder.sv - HDB3-family encoder with parametrised zero-run substitution
// Purpose: accepts NRZ bits, substitutes each run of N_ZEROS zeros with
// 000V or B00V, and emits signed ternary symbols N_ZEROS accepts later.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of hdb3_bnzs_encoder_if (input bit, output symbol)
module hdb3_bnzs_encoder
  import hdb3_pkg::*;
#(
  parameter int N_ZEROS = 4
) (
  input logic                  clk,
  input logic                  rst,
  hdb3_bnzs_encoder_if.slave   bus
);

  localparam int ZW = $clog2(N_ZEROS + 1);

  kind_t         sr [N_ZEROS];
  logic [ZW-1:0] zrun;
  logic [ZW-1:0] fill;
  logic          par;

  logic accept;
  logic full;
  logic hit;

  assign accept = bus.in_valid;
  assign full   = (fill == ZW'(N_ZEROS));
  // This zero completes a run of N_ZEROS and becomes a V.
  assign hit    = !bus.in_data && (zrun == ZW'(N_ZEROS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_ZEROS; i++) sr[i] <= K_ZERO;
      zrun          <= '0;
      fill          <= '0;
      par           <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= accept && full;
      if (accept) begin
        for (int i = N_ZEROS - 1; i > 0; i--) sr[i] <= sr[i-1];
        // Even pulse count: the first zero of the run, now reaching the
        // oldest slot, becomes B so the V keeps the line balanced.
        if (hit && !par) sr[N_ZEROS-1] <= K_B;
        sr[0] <= bus.in_data ? K_ONE : (hit ? K_V : K_ZERO);

        if (bus.in_data || hit) zrun <= '0;
        else                    zrun <= zrun + ZW'(1);

        if (hit)              par <= 1'b0;
        else if (bus.in_data) par <= ~par;

        if (!full) fill <= fill + ZW'(1);
      end
    end
  end

  hdb3_polarity u_polarity (
    .clk     (clk),
    .rst     (rst),
    .en      (accept && full),
    .kind    (sr[N_ZEROS-1]),
    .out_sym (bus.out_sym),
    .out_v   (bus.out_v),
    .out_b   (bus.out_b)
  );

endmodule

// File: tb/tb_hdb3_bnzs_encoder.sv
// tb/tb_hdb3_bnzs_encoder.sv - directed and random checks of hdb3_bnzs_encoder
module tb_hdb3_bnzs_encoder;
  import hdb3_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hdb3_bnzs_encoder_if if4 ();
  hdb3_bnzs_encoder_if if3 ();

  hdb3_bnzs_encoder #(.N_ZEROS(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
  hdb3_bnzs_encoder #(.N_ZEROS(3)) dut3 (.clk(clk), .rst(rst), .bus(if3.slave));

  int checks   = 0;
  int failures = 0;

  logic [1:0] s4[$];
  logic       v4[$];
  logic       b4[$];
  logic [1:0] s3[$];
  logic       v3[$];
  logic       b3[$];
  logic       inq[$];

  always @(negedge clk) begin
    if (if4.out_valid === 1'b1) begin
      s4.push_back(if4.out_sym);
      v4.push_back(if4.out_v);
      b4.push_back(if4.out_b);
    end
    if (if3.out_valid === 1'b1) begin
      s3.push_back(if3.out_sym);
      v3.push_back(if3.out_v);
      b3.push_back(if3.out_b);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send4(input logic v, input logic d);
    @(negedge clk);
    if4.in_valid = v;
    if4.in_data  = d;
  endtask

  task automatic send3(input logic v, input logic d);
    @(negedge clk);
    if3.in_valid = v;
    if3.in_data  = d;
  endtask

  task automatic clear_q();
    s4.delete(); v4.delete(); b4.delete();
    s3.delete(); v3.delete(); b3.delete();
    inq.delete();
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_seq(input string t, input int n,
                           input logic [1:0] gs[$], input logic gv[$], input logic gb[$],
                           input logic [1:0] es[8], input logic [7:0] ev, input logic [7:0] eb);
    chk({t, "_count"}, gs.size(), n);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_sym%0d", t, i), gs[i], es[i]);
      chk($sformatf("%s_v%0d", t, i), gv[i], ev[i]);
      chk($sformatf("%s_b%0d", t, i), gb[i], eb[i]);
    end
  endtask

  logic [1:0] e1 [8];
  logic [1:0] e2 [8];
  logic [1:0] e3 [8];
  logic [1:0] e5 [8];
  logic [9:0] bits1;

  initial begin
    e1 = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b11, 2'b00, 2'b00};
    e2 = '{2'b01, 2'b00, 2'b00, 2'b01, 2'b11, 2'b00, 2'b00, 2'b11};
    e3 = '{2'b01, 2'b11, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00};
    e5 = '{2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
    bits1 = 10'b0000_100001; // bit i sent i-th: 1,0,0,0,0,1,0,0,0,0

    rst = 1'b1;
    if4.in_valid = 1'b0; if4.in_data = 1'b0;
    if3.in_valid = 1'b0; if3.in_data = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", if4.out_valid, 1'b0);
    chk("rst_out_sym", if4.out_sym, 2'b00);
    chk("rst_out_v", if4.out_v, 1'b0);
    chk("rst_out_b", if4.out_b, 1'b0);
    chk("rst_out_valid3", if3.out_valid, 1'b0);
    rst = 1'b0;

    // 1,0,0,0,0,1 plus flush: 000V after an odd pulse count
    clear_q();
    for (int i = 0; i < 10; i++) send4(1'b1, bits1[i]);
    send4(1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check_seq("t1", 6, s4, v4, b4, e1, 8'b0001_0000, 8'b0000_0000);
    chk("hold_valid", if4.out_valid, 1'b0);
    chk("hold_sym", if4.out_sym, 2'b11);

    // eight zeros: two B00V substitutions with alternating signs
    pulse_reset();
    clear_q();
    for (int i = 0; i < 12; i++) send4(1'b1, 1'b0);
    send4(1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check_seq("t2", 8, s4, v4, b4, e2, 8'b1000_1000, 8'b0001_0001);

    // N_ZEROS=3: 1,1,0,0,0 gives B0V
    pulse_reset();
    clear_q();
    for (int i = 0; i < 8; i++) send3(1'b1, (i < 2) ? 1'b1 : 1'b0);
    send3(1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check_seq("t3", 5, s3, v3, b3, e3, 8'b0001_0000, 8'b0000_0100);

    // same input as t1 with random gaps
    pulse_reset();
    clear_q();
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(0, 2)) send4(1'b0, 1'b1);
      send4(1'b1, bits1[i]);
    end
    send4(1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check_seq("t4", 6, s4, v4, b4, e1, 8'b0001_0000, 8'b0000_0000);

    // asynchronous reset after three zeros discards them
    pulse_reset();
    for (int i = 0; i < 3; i++) send4(1'b1, 1'b0);
    send4(1'b0, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("async_rst_valid", if4.out_valid, 1'b0);
    #1 rst = 1'b0;
    clear_q();
    for (int i = 0; i < 8; i++) send4(1'b1, 1'b0);
    send4(1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check_seq("t5", 4, s4, v4, b4, e5, 8'b0000_1000, 8'b0000_0001);

    // random stream: decode by polarity and check line invariants
    pulse_reset();
    clear_q();
    for (int i = 0; i < 3000; i++) begin
      logic d;
      if ($urandom_range(0, 3) == 0) send4(1'b0, 1'b0);
      d = ($urandom_range(0, 2) == 0);
      inq.push_back(d);
      send4(1'b1, d);
    end
    send4(1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("rand_count", s4.size(), inq.size() - 4);
    begin
      logic [1:0] lastp = SYM_NEG;
      logic [1:0] lastv = SYM_ZERO;
      logic       dec[$];
      int dec_err = 0, alt_err = 0, flag_err = 0, b_err = 0;
      int run = 0, maxrun = 0, vcount = 0;
      for (int i = 0; i < s4.size(); i++) begin
        dec.push_back(s4[i] != SYM_ZERO);
        if (s4[i] == SYM_ZERO) begin
          run++;
          if (run > maxrun) maxrun = run;
          if (v4[i] || b4[i]) flag_err++;
        end else begin
          run = 0;
          if (s4[i] == lastp) begin
            vcount++;
            for (int j = i - 3; j <= i; j++) if (j >= 0) dec[j] = 1'b0;
            if (!v4[i]) flag_err++;
            if (lastv != SYM_ZERO && lastv == s4[i]) alt_err++;
            lastv = s4[i];
            if (i >= 3 && b4[i-3] && s4[i-3] != s4[i]) b_err++;
          end else begin
            if (v4[i]) flag_err++;
            lastp = s4[i];
          end
        end
      end
      for (int i = 0; i < dec.size(); i++) if (dec[i] !== inq[i]) dec_err++;
      chk("rand_decode_errors", dec_err, 0);
      chk("rand_max_zero_run_ok", (maxrun <= 3), 1'b1);
      chk("rand_v_alternation_errors", alt_err, 0);
      chk("rand_v_flag_errors", flag_err, 0);
      chk("rand_b_sign_errors", b_err, 0);
      chk("rand_v_seen", (vcount > 0), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
